pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Parametrised program-counter sequencer for the fetch stage; next generation of the basic PC register.
//  Holds the fetch PC and advances it by INSTR_BYTES on each accepted fetch.
//  Accepts branch/jump redirects, call/return via a return-address stack (RAS), traps and stalls.
//  Presents the PC to instruction memory with a valid/ready handshake.
// PARAMETERS
//  XLEN          32     PC and address width in bits
//  INSTR_BYTES   4      PC increment; power of two, >=1; low log2(INSTR_BYTES) PC bits always 0
//  RESET_VECTOR  0      PC value loaded while reset is asserted
//  TRAP_VECTOR   'h80   PC value loaded on trap
//  RAS_DEPTH     4      return-address stack entries, >=2
// PORTS
//  clock            in   1     rising-edge clock
//  reset            in   1     asynchronous, active-low reset
//  stall            in   1     hold PC (pipeline backpressure)
//  redirect_valid   in   1     branch/jump taken; load redirect_target
//  redirect_target  in   XLEN  redirect destination
//  call_push        in   1     with redirect_valid: push pc+INSTR_BYTES onto RAS
//  ret_pop          in   1     return: load RAS top and pop
//  trap             in   1     exception; load TRAP_VECTOR, flush RAS
//  fetch_ready      in   1     instruction memory accepts pc this cycle
//  fetch_valid      out  1     pc is a valid fetch request
//  pc               out  XLEN  current fetch PC
//  ras_empty        out  1     RAS holds 0 entries
//  ras_full         out  1     RAS holds RAS_DEPTH entries
//  misaligned_err   out  1     one-cycle pulse: redirect_target had nonzero low bits
//  ras_underflow    out  1     one-cycle pulse: ret_pop with empty RAS
// BEHAVIOUR
//  Reset (reset=0, async)
//   - pc=RESET_VECTOR, state=BOOT, fetch_valid=0, RAS count=0, ras_empty=1, ras_full=0, pulses=0.
//  FSM
//   - BOOT -> RUN on first edge after reset release.
//   - RUN -> BUBBLE on any taken redirect/ret/trap.
//   - BUBBLE -> RUN next edge, unless another redirect/ret/trap.
//   - fetch_valid = (state==RUN) & ~stall, combinational from registered state.
//  Per-edge priority (first match wins)
//   1. trap: pc<=TRAP_VECTOR, RAS count<=0, state<=BUBBLE. Overrides stall and all other inputs.
//   2. redirect_valid: pc<=redirect_target with low bits cleared, state<=BUBBLE.
//      If the cleared low bits were nonzero, misaligned_err=1 for one cycle.
//      If call_push=1, also push pc+INSTR_BYTES (PC of the call plus one instruction).
//      Overrides stall. Any ret_pop in the same cycle is ignored.
//   3. ret_pop, RAS non-empty: pc<=top entry, count-1, state<=BUBBLE. Overrides stall.
//   4. ret_pop, RAS empty: ras_underflow=1 for one cycle; fall through to rule 5.
//   5. fetch_valid & fetch_ready: pc<=pc+INSTR_BYTES.
//   6. Otherwise (stall, ~fetch_ready, BOOT/BUBBLE): hold pc.
//  Other input rules
//   - call_push without redirect_valid is ignored.
//  Arithmetic
//   - pc+INSTR_BYTES wraps modulo 2^XLEN; no flag.
//   - Push value is computed from pc before the update.
//  RAS
//   - Circular buffer indexed by a top pointer.
//   - Push when full overwrites the oldest entry; count saturates at RAS_DEPTH.
//   - ras_full/ras_empty are registered from count.
//  Latency
//   - A redirect/ret/trap at edge N gives new pc visible after N.
//   - fetch_valid is 0 for one cycle, then 1 from edge N+1.
//  Reset mid-operation
//   - Asserting reset immediately forces the reset values, discards RAS contents and drops fetch_valid.
// TESTING
//  - Reset release, fetch_ready=1: pc 0 (valid=0), 0 (valid=1), 4, 8, 12 on successive edges.
//  - Stall high 3 cycles at pc=8: pc stays 8, fetch_valid=0; advances to 12 the cycle after stall drops.
//  - At pc=0x10: redirect 0x100 with call_push -> pc=0x100, one bubble.
//    Then ret_pop -> pc=0x14, ras_empty=1.
//  - 5 calls with RAS_DEPTH=4: ras_full=1.
//    4 rets return the last 4 pushed addresses (newest first); 5th ret pulses ras_underflow and pc advances.
//  - Trap together with redirect 0x200 and stall at pc=0x40: pc=0x80, RAS flushed, misaligned_err=0.
//    Redirect to 0x103: pc=0x100, misaligned_err pulses.
//  - pc=0xFFFFFFFC accepted fetch -> pc=0; reset asserted mid-bubble -> pc=0, fetch_valid=0 asynchronously.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter sequencer: sequential fetch with a valid/ready
// handshake, plus branch redirects, traps and a circular return-address stack.
module pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter int              INSTR_BYTES  = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h80,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            call_push,
  input  logic            ret_pop,
  input  logic            trap,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] pc,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            misaligned_err,
  output logic            ras_underflow
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [XLEN-1:0]  LOW_MASK  = XLEN'(INSTR_BYTES - 1);
  localparam logic [XLEN-1:0]  PC_STEP   = XLEN'(INSTR_BYTES);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(RAS_DEPTH);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [XLEN-1:0]   pc_next;
  logic [XLEN-1:0]   pc_plus;
  logic [XLEN-1:0]   ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  top, top_next, top_inc, top_dec;
  logic [CNT_W-1:0]  count, count_next;
  logic              push;
  logic              taken;
  logic              mis_next;
  logic              und_next;

  assign fetch_valid = (state == RUN) & ~stall;
  assign pc_plus     = pc + PC_STEP;

  // Top pointer wraps explicitly so non-power-of-two depths still form a ring.
  assign top_inc = (top == PTR_LAST) ? '0 : top + 1'b1;
  assign top_dec = (top == '0) ? PTR_LAST : top - 1'b1;

  always_comb begin
    pc_next    = pc;
    state_next = state;
    top_next   = top;
    count_next = count;
    push       = 1'b0;
    taken      = 1'b0;
    mis_next   = 1'b0;
    und_next   = 1'b0;

    if (trap) begin
      pc_next    = TRAP_VECTOR;
      count_next = '0;
      taken      = 1'b1;
    end else if (redirect_valid) begin
      pc_next  = redirect_target & ~LOW_MASK;
      mis_next = |(redirect_target & LOW_MASK);
      taken    = 1'b1;
      if (call_push) begin
        push     = 1'b1;
        top_next = top_inc;
        if (count != CNT_FULL) begin
          count_next = count + 1'b1;
        end
      end
    end else if (ret_pop && (count != '0)) begin
      pc_next    = ras_mem[top];
      top_next   = top_dec;
      count_next = count - 1'b1;
      taken      = 1'b1;
    end else begin
      // An empty-stack return only flags; the fetch stream carries on.
      und_next = ret_pop;
      if (fetch_valid && fetch_ready) begin
        pc_next = pc_plus;
      end
    end

    case (state)
      BOOT:    state_next = taken ? BUBBLE : RUN;
      RUN:     state_next = taken ? BUBBLE : RUN;
      BUBBLE:  state_next = taken ? BUBBLE : RUN;
      default: state_next = BOOT;
    endcase
  end

  // A push onto a full stack lands on the oldest slot, overwriting it.
  always_ff @(posedge clock) begin
    if (push) begin
      ras_mem[top_inc] <= pc_plus;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= BOOT;
      pc             <= RESET_VECTOR;
      top            <= '0;
      count          <= '0;
      ras_empty      <= 1'b1;
      ras_full       <= 1'b0;
      misaligned_err <= 1'b0;
      ras_underflow  <= 1'b0;
    end else begin
      state          <= state_next;
      pc             <= pc_next;
      top            <= top_next;
      count          <= count_next;
      ras_empty      <= (count_next == '0);
      ras_full       <= (count_next == CNT_FULL);
      misaligned_err <= mis_next;
      ras_underflow  <= und_next;
    end
  end

endmodule
